// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache (single-word reads)
// and the vector D-cache (burst reads / burst writes), one transaction at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  i_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       i_vis_addr,
  input  logic [1:0]                  d_vis_signal,
  input  logic [ADDR_WIDTH-1:0]       d_vis_addr,
  input  logic [LEN-1:0]              d_writen_data,
  input  logic [ENTRY_INDEX_SIZE-1:0] d_write_length,
  output logic [1:0]                  mem_status,
  output logic [LEN-1:0]              mem_data,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic                        ram_we,
  output logic [LEN-1:0]              ram_wdata,
  input  logic [LEN-1:0]              ram_rdata
);
  localparam logic [1:0] MEM_NOP          = 2'd0;
  localparam logic [1:0] MEM_READ         = 2'd1;
  localparam logic [1:0] MEM_WRITE        = 2'd2;
  localparam logic [1:0] MEM_READ_BURST   = 2'd3;
  localparam logic [1:0] MEM_RESTING      = 2'd0;
  localparam logic [1:0] MEM_INST_WORKING = 2'd1;
  localparam logic [1:0] MEM_DATA_WORKING = 2'd2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_INST    = 2'd1;
  localparam logic [1:0] S_DATA_RD = 2'd2;
  localparam logic [1:0] S_DATA_WR = 2'd3;

  localparam int CW = ENTRY_INDEX_SIZE + 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(LEN / 8);
  localparam logic [CW-1:0] VS  = CW'(VECTOR_SIZE);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] beat, total, wr_total;
  logic          last_was_data;
  logic          i_req, d_req, grant_inst;

  // Instruction fetch only wins a tie when the previous grant went to data.
  always_comb begin
    i_req      = (i_vis_signal == MEM_READ);
    d_req      = (d_vis_signal == MEM_READ_BURST) || (d_vis_signal == MEM_WRITE);
    grant_inst = i_req && (!d_req || last_was_data);
    wr_total   = (d_write_length == '0) ? VS : {1'b0, d_write_length};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mem_status    <= MEM_RESTING;
      mem_data      <= '0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_wdata     <= '0;
      beat          <= '0;
      total         <= '0;
      last_was_data <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ram_we <= 1'b0;
          beat   <= '0;
          if (grant_inst) begin
            state         <= S_INST;
            mem_status    <= MEM_INST_WORKING;
            ram_addr      <= i_vis_addr;
            total         <= ONE;
            last_was_data <= 1'b0;
          end else if (d_req) begin
            state         <= (d_vis_signal == MEM_WRITE) ? S_DATA_WR : S_DATA_RD;
            mem_status    <= MEM_DATA_WORKING;
            ram_addr      <= d_vis_addr;
            total         <= (d_vis_signal == MEM_WRITE) ? wr_total : VS;
            last_was_data <= 1'b1;
          end
        end
        S_INST: begin
          mem_data   <= ram_rdata;
          mem_status <= MEM_RESTING;
          state      <= S_IDLE;
        end
        S_DATA_RD: begin
          if (d_vis_signal != MEM_READ_BURST) begin
            mem_status <= MEM_RESTING;
            state      <= S_IDLE;
          end else begin
            mem_data <= ram_rdata;
            ram_addr <= ram_addr + STRIDE;
            beat     <= beat + ONE;
            if (beat == total - ONE) begin
              mem_status <= MEM_RESTING;
              state      <= S_IDLE;
            end
          end
        end
        S_DATA_WR: begin
          // A beat registered last cycle is committed by memory at this edge; step past it.
          if (ram_we) ram_addr <= ram_addr + STRIDE;
          if (d_vis_signal != MEM_WRITE || beat == total) begin
            ram_we     <= 1'b0;
            mem_status <= MEM_RESTING;
            state      <= S_IDLE;
          end else begin
            ram_we    <= 1'b1;
            ram_wdata <= d_writen_data;
            beat      <= beat + ONE;
          end
        end
        default: begin
          ram_we     <= 1'b0;
          mem_status <= MEM_RESTING;
          state      <= S_IDLE;
        end
      endcase
    end
  end
endmodule
